adc_serial_emulator_4ch: RTL and testbench



---
 rtl/adc_serial_emulator_4ch_pkg.sv | 20 ++
 rtl/adc_serial_emulator_4ch_if.sv | 27 ++
 rtl/adc_serial_emulator_4ch_shifter.sv | 31 +++
 rtl/adc_serial_emulator_4ch.sv | 136 +++++++++++++
 tb/tb_adc_serial_emulator_4ch.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_serial_emulator_4ch_pkg.sv
// Shared constants and types for the 4-lane serial ADC emulator.
package adc_emu_pkg;

    localparam int unsigned DEF_DATA_W = 12;
    localparam int unsigned DEF_LEAD   = 2;
    localparam int unsigned DEF_CNT_W  = 8;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned A0 = 0;
    localparam int unsigned A1 = 1;
    localparam int unsigned B0 = 2;
    localparam int unsigned B1 = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT
    } emu_state_t;

endpackage

// File: rtl/adc_serial_emulator_4ch_if.sv
// Serial link plus sample-word handshake between the emulator and its neighbours.
interface adc_serial_emulator_4ch_if
    import adc_emu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              ad_cs;
    logic [1:0]        ad_sdata_a;
    logic [1:0]        ad_sdata_b;
    logic [DATA_W-1:0] smp_a0;
    logic [DATA_W-1:0] smp_a1;
    logic [DATA_W-1:0] smp_b0;
    logic [DATA_W-1:0] smp_b1;
    logic              smp_valid;
    logic              smp_ready;
    logic              sample_req;

    modport slave (
        input  ad_cs, smp_a0, smp_a1, smp_b0, smp_b1, smp_valid,
        output ad_sdata_a, ad_sdata_b, smp_ready, sample_req
    );

    modport master (
        output ad_cs, smp_a0, smp_a1, smp_b0, smp_b1, smp_valid,
        input  ad_sdata_a, ad_sdata_b, smp_ready, sample_req
    );
endinterface

// File: rtl/adc_serial_emulator_4ch_shifter.sv
// One lane: parallel-load, MSB-first shift register with a registered serial bit.
module adc_frame_shifter #(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    output logic              sout
);

    logic [DATA_W-1:0] sr;

    // Line idles low whenever no bit is being shifted out.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr   <= '0;
            sout <= 1'b0;
        end else if (load) begin
            sr   <= load_data;
            sout <= 1'b0;
        end else begin
            sout <= shift_en ? sr[DATA_W-1] : 1'b0;
            if (shift_en) begin
                sr <= {sr[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/adc_serial_emulator_4ch.sv
// ADC-side responder: on each CS rising edge, serialises four sample words
// MSB-first so they land in the receiver's load window.
module adc_serial_emulator_4ch
    import adc_emu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEAD   = DEF_LEAD,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    adc_serial_emulator_4ch_if.slave   bus,
    output logic                       busy,
    output logic [CNT_W-1:0]           underrun_cnt,
    output logic [CNT_W-1:0]           abort_cnt
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + LEAD + 1);
    localparam int unsigned LEAD_LAST = (LEAD > 1) ? LEAD - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    emu_state_t             state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   cs_prev;
    logic                   cs_edge;
    logic                   shift_en;
    logic                   smp_ready_q;
    logic                   sample_req_q;
    logic [DATA_W-1:0]      smp_in    [NUM_LANES];
    logic [DATA_W-1:0]      shadow    [NUM_LANES];
    logic [DATA_W-1:0]      last_sent [NUM_LANES];
    logic [DATA_W-1:0]      load_word [NUM_LANES];
    logic [NUM_LANES-1:0]   sout;

    assign cs_edge  = bus.ad_cs && !cs_prev;
    assign shift_en = (state == S_SHIFT) && (bit_cnt < BIT_CNT_W'(DATA_W));
    assign busy     = (state != S_IDLE);

    assign bus.smp_ready  = smp_ready_q;
    assign bus.sample_req = sample_req_q;
    assign bus.ad_sdata_a = {sout[A1], sout[A0]};
    assign bus.ad_sdata_b = {sout[B1], sout[B0]};

    // Fresh shadow wins; otherwise the previous frame is repeated.
    always_comb begin
        smp_in[A0] = bus.smp_a0;
        smp_in[A1] = bus.smp_a1;
        smp_in[B0] = bus.smp_b0;
        smp_in[B1] = bus.smp_b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            load_word[i] = smp_ready_q ? last_sent[i] : shadow[i];
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        adc_frame_shifter #(
            .DATA_W (DATA_W)
        ) u_shifter (
            .clk       (clk),
            .reset     (reset),
            .load      (cs_edge),
            .load_data (load_word[i]),
            .shift_en  (shift_en),
            .sout      (sout[i])
        );
    end

    // Frame FSM, shadow handshake and status counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            cs_prev      <= 1'b0;
            smp_ready_q  <= 1'b1;
            sample_req_q <= 1'b0;
            underrun_cnt <= '0;
            abort_cnt    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                shadow[i]    <= '0;
                last_sent[i] <= '0;
            end
        end else begin
            cs_prev      <= bus.ad_cs;
            sample_req_q <= 1'b0;

            if (cs_edge) begin
                if (!smp_ready_q) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        last_sent[i] <= shadow[i];
                    end
                    smp_ready_q  <= 1'b1;
                    sample_req_q <= 1'b1;
                end else if (underrun_cnt != CNT_MAX) begin
                    underrun_cnt <= underrun_cnt + CNT_W'(1);
                end
                if (state != S_IDLE && abort_cnt != CNT_MAX) begin
                    abort_cnt <= abort_cnt + CNT_W'(1);
                end
                state   <= (LEAD > 1) ? S_LEAD : S_SHIFT;
                bit_cnt <= '0;
            end else begin
                case (state)
                    S_LEAD: begin
                        if (bit_cnt == BIT_CNT_W'(LEAD_LAST)) begin
                            state   <= S_SHIFT;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                    S_SHIFT: begin
                        if (bit_cnt == BIT_CNT_W'(DATA_W)) begin
                            state   <= S_IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end

            // Only possible while the shadow is empty, so never clashes with a consume.
            if (bus.smp_valid && smp_ready_q) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    shadow[i] <= smp_in[i];
                end
                smp_ready_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_emulator_4ch.sv
// Directed bench for the 4-lane serial ADC emulator.
module tb_adc_serial_emulator_4ch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [7:0] underrun_cnt;
    logic [7:0] abort_cnt;

    int tests_run = 0;
    int failed    = 0;

    logic [11:0] cap      [4];
    logic        rdy_log  [15];
    logic        busy_log [15];
    logic        a0_log   [15];
    logic        req_log  [15];
    logic        drop_valid_at1 = 1'b0;

    adc_serial_emulator_4ch_if #(.DATA_W(12)) bus ();

    adc_serial_emulator_4ch dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .underrun_cnt (underrun_cnt),
        .abort_cnt    (abort_cnt)
    );

    always #5 clk = ~clk;

    // Entered just after the edge that sees CS high; logs edges E0..E0+14.
    task automatic capture_after_cs;
        logic [3:0] lanes;
        @(negedge clk);
        bus.ad_cs  = 1'b0;
        rdy_log[0] = bus.smp_ready;
        req_log[0] = bus.sample_req;
        busy_log[0] = busy;
        a0_log[0]  = bus.ad_sdata_a[0];
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            rdy_log[n]  = bus.smp_ready;
            req_log[n]  = bus.sample_req;
            busy_log[n] = busy;
            a0_log[n]   = bus.ad_sdata_a[0];
            if (n == 1 && drop_valid_at1) bus.smp_valid = 1'b0;
            if (n >= 2 && n <= 13) begin
                lanes = {bus.ad_sdata_b[1], bus.ad_sdata_b[0],
                         bus.ad_sdata_a[1], bus.ad_sdata_a[0]};
                for (int l = 0; l < 4; l++) cap[l][13-n] = lanes[l];
            end
        end
    endtask

    task automatic cs_and_capture;
        @(negedge clk);
        bus.ad_cs = 1'b1;
        capture_after_cs();
    endtask

    task automatic load_set(input logic [11:0] a0, a1, b0, b1);
        bit done = 1'b0;
        @(negedge clk);
        bus.smp_a0 = a0; bus.smp_a1 = a1; bus.smp_b0 = b0; bus.smp_b1 = b1;
        bus.smp_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            done = bus.smp_ready;
            @(negedge clk);
        end
        bus.smp_valid = 1'b0;
        if (!done) begin
            tests_run++; failed++;
            $display("FAIL load_timeout: smp_ready never seen within 64 cycles");
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.ad_sdata_a !== 2'b00 || bus.ad_sdata_b !== 2'b00) begin
            failed++; $display("FAIL reset_sdata: got a=%b b=%b want 00 00", bus.ad_sdata_a, bus.ad_sdata_b);
        end
        tests_run++;
        if (bus.sample_req !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL reset_flags: got req=%b busy=%b want 0 0", bus.sample_req, busy);
        end
        tests_run++;
        if (bus.smp_ready !== 1'b1) begin
            failed++; $display("FAIL reset_ready: got %b want 1", bus.smp_ready);
        end
        tests_run++;
        if (underrun_cnt !== 8'd0 || abort_cnt !== 8'd0) begin
            failed++; $display("FAIL reset_cnt: got u=%0d a=%0d want 0 0", underrun_cnt, abort_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_loopback;
        logic [11:0] exp [4];
        exp[0] = 12'hA5C; exp[1] = 12'h123; exp[2] = 12'hFFF; exp[3] = 12'h000;
        load_set(exp[0], exp[1], exp[2], exp[3]);
        cs_and_capture();
        for (int l = 0; l < 4; l++) begin
            tests_run++;
            if (cap[l] !== exp[l]) begin
                failed++; $display("FAIL loopback_lane%0d: got %h want %h", l, cap[l], exp[l]);
            end
        end
        tests_run++;
        if (req_log[0] !== 1'b1 || req_log[1] !== 1'b0) begin
            failed++; $display("FAIL loopback_sample_req: got %b,%b want 1,0", req_log[0], req_log[1]);
        end
        tests_run++;
        if (bus.smp_ready !== 1'b1) begin
            failed++; $display("FAIL loopback_ready: got %b want 1", bus.smp_ready);
        end
        tests_run++;
        if (underrun_cnt !== 8'd0) begin
            failed++; $display("FAIL loopback_underrun: got %0d want 0", underrun_cnt);
        end
    endtask

    task automatic test_bit_timing;
        load_set(12'h800, 12'h000, 12'h000, 12'h000);
        cs_and_capture();
        for (int n = 1; n <= 14; n++) begin
            tests_run++;
            if (a0_log[n] !== (n == 2)) begin
                failed++; $display("FAIL timing_a0_E0+%0d: got %b want %b", n, a0_log[n], n == 2);
            end
            tests_run++;
            if (busy_log[n] !== (n <= 13)) begin
                failed++; $display("FAIL timing_busy_E0+%0d: got %b want %b", n, busy_log[n], n <= 13);
            end
        end
    endtask

    task automatic test_underrun;
        do_reset();
        load_set(12'h3C3, 12'h3C3, 12'h3C3, 12'h3C3);
        for (int f = 0; f < 3; f++) begin
            cs_and_capture();
            for (int l = 0; l < 4; l++) begin
                tests_run++;
                if (cap[l] !== 12'h3C3) begin
                    failed++; $display("FAIL underrun_frame%0d_lane%0d: got %h want 3c3", f, l, cap[l]);
                end
            end
        end
        tests_run++;
        if (underrun_cnt !== 8'd2) begin
            failed++; $display("FAIL underrun_cnt2: got %0d want 2", underrun_cnt);
        end
        for (int f = 0; f < 300; f++) cs_and_capture();
        tests_run++;
        if (underrun_cnt !== 8'd255) begin
            failed++; $display("FAIL underrun_sat: got %0d want 255", underrun_cnt);
        end
        tests_run++;
        if (abort_cnt !== 8'd0) begin
            failed++; $display("FAIL underrun_no_abort: got %0d want 0", abort_cnt);
        end
    endtask

    task automatic test_backpressure;
        logic [11:0] x [4];
        logic [11:0] y [4];
        x[0] = 12'h111; x[1] = 12'h222; x[2] = 12'h333; x[3] = 12'h444;
        y[0] = 12'hABC; y[1] = 12'hDEF; y[2] = 12'h987; y[3] = 12'h654;
        do_reset();
        load_set(x[0], x[1], x[2], x[3]);
        @(negedge clk);
        bus.smp_a0 = y[0]; bus.smp_a1 = y[1]; bus.smp_b0 = y[2]; bus.smp_b1 = y[3];
        bus.smp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.smp_ready !== 1'b0) begin
                failed++; $display("FAIL bp_ready_held%0d: got %b want 0", i, bus.smp_ready);
            end
        end
        drop_valid_at1 = 1'b1;
        cs_and_capture();
        drop_valid_at1 = 1'b0;
        tests_run++;
        if (rdy_log[0] !== 1'b1 || rdy_log[1] !== 1'b0) begin
            failed++; $display("FAIL bp_accept_after_E0: got %b,%b want 1,0", rdy_log[0], rdy_log[1]);
        end
        for (int l = 0; l < 4; l++) begin
            tests_run++;
            if (cap[l] !== x[l]) begin
                failed++; $display("FAIL bp_frameX_lane%0d: got %h want %h", l, cap[l], x[l]);
            end
        end
        cs_and_capture();
        for (int l = 0; l < 4; l++) begin
            tests_run++;
            if (cap[l] !== y[l]) begin
                failed++; $display("FAIL bp_frameY_lane%0d: got %h want %h", l, cap[l], y[l]);
            end
        end
        tests_run++;
        if (underrun_cnt !== 8'd0) begin
            failed++; $display("FAIL bp_underrun: got %0d want 0", underrun_cnt);
        end
    endtask

    task automatic test_abort;
        do_reset();
        load_set(12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0);
        @(negedge clk);
        bus.ad_cs = 1'b1;
        @(negedge clk);
        bus.ad_cs = 1'b0;
        load_set(12'h555, 12'h555, 12'h555, 12'h555);
        repeat (4) @(negedge clk);
        // CS rises so that the second edge lands at E0+8
        cs_and_capture();
        tests_run++;
        if (abort_cnt !== 8'd1) begin
            failed++; $display("FAIL abort_cnt: got %0d want 1", abort_cnt);
        end
        for (int l = 0; l < 4; l++) begin
            tests_run++;
            if (cap[l] !== 12'h555) begin
                failed++; $display("FAIL abort_lane%0d: got %h want 555", l, cap[l]);
            end
        end
        tests_run++;
        if (a0_log[1] !== 1'b0 || a0_log[2] !== 1'b0 || a0_log[3] !== 1'b1) begin
            failed++; $display("FAIL abort_timing: got %b%b%b want 001", a0_log[1], a0_log[2], a0_log[3]);
        end
        tests_run++;
        if (req_log[0] !== 1'b1 || underrun_cnt !== 8'd0) begin
            failed++; $display("FAIL abort_req_underrun: got req=%b u=%0d want 1 0", req_log[0], underrun_cnt);
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        bus.ad_cs = 1'b1;
        @(negedge clk);
        bus.ad_cs = 1'b0;
        load_set(12'h777, 12'h777, 12'h777, 12'h777);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.ad_sdata_a !== 2'b00 || bus.ad_sdata_b !== 2'b00 || busy !== 1'b0) begin
            failed++; $display("FAIL midreset_out: got a=%b b=%b busy=%b want 00 00 0", bus.ad_sdata_a, bus.ad_sdata_b, busy);
        end
        tests_run++;
        if (bus.smp_ready !== 1'b1) begin
            failed++; $display("FAIL midreset_ready: got %b want 1", bus.smp_ready);
        end
        tests_run++;
        if (underrun_cnt !== 8'd0 || abort_cnt !== 8'd0) begin
            failed++; $display("FAIL midreset_cnt: got u=%0d a=%0d want 0 0", underrun_cnt, abort_cnt);
        end
        reset = 1'b0;
        cs_and_capture();
        for (int l = 0; l < 4; l++) begin
            tests_run++;
            if (cap[l] !== 12'h000) begin
                failed++; $display("FAIL midreset_lane%0d: got %h want 000", l, cap[l]);
            end
        end
        tests_run++;
        if (underrun_cnt !== 8'd1 || req_log[0] !== 1'b0) begin
            failed++; $display("FAIL midreset_underrun: got u=%0d req=%b want 1 0", underrun_cnt, req_log[0]);
        end
    endtask

    initial begin
        bus.ad_cs = 1'b0;
        bus.smp_valid = 1'b0;
        bus.smp_a0 = '0; bus.smp_a1 = '0; bus.smp_b0 = '0; bus.smp_b1 = '0;
        test_reset();
        test_loopback();
        test_bit_timing();
        test_underrun();
        test_backpressure();
        test_abort();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
